mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: REG_WIDTH, 8, data bus width.
REQ-002 Parameter: ADDR_WIDTH, 16, address bus width.
REQ-003 phi1  input  1  clock; all state updates on rising edge.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 fetch_req  input  1  fetcher requests a bus read.
REQ-006 fetch_addr  input  ADDR_WIDTH  fetcher read address.
REQ-007 exec_req  input  1  execute unit requests a bus access.
REQ-008 exec_we  input  1  execute access is a write.
REQ-009 exec_addr  input  ADDR_WIDTH  execute access address.
REQ-010 exec_wdata  input  REG_WIDTH  execute write data.
REQ-011 exec_lock  input  1  keep bus ownership with execute (read-modify-write).
REQ-012 dma_start  input  1  one-cycle strobe from the $4014 write decode.
REQ-013 dma_page  input  REG_WIDTH  DMA source page, sampled with dma_start.
REQ-014 mem_rdata  input  REG_WIDTH  memory read data, valid in the cycle mem_addr is driven.
REQ-015 mem_addr  output  ADDR_WIDTH  registered bus address.
REQ-016 mem_wdata  output  REG_WIDTH  registered write data.
REQ-017 mem_we  output  1  registered write enable.
REQ-018 fetch_gnt  output  1  fetcher owns the bus in this cycle.
REQ-019 exec_gnt  output  1  execute unit owns the bus in this cycle.
REQ-020 dma_busy  output  1  DMA active; CPU halted.

Function
REQ-021 States SHALL be IDLE, FETCH, EXEC, DMA_DUMMY, DMA_ALIGN, DMA_READ and DMA_WRITE.
- Owner selection SHALL occur at each rising phi1 edge.
- Priority SHALL be DMA > exec > fetch.
- Outputs registered: a request sampled at edge k drives the grant and bus signals after edge k.
- The requester SHALL sample mem_rdata at edge k+1.
REQ-022 While exec_gnt=1 and exec_lock=1: exec SHALL retain the bus; a pending DMA SHALL wait until the lock drops.
REQ-023 With no request, the block SHALL enter IDLE: mem_we=0, grants=0, mem_addr holds its last value.
REQ-024 A phase bit SHALL toggle every cycle from reset.
- dma_start SHALL latch dma_page and enter DMA_DUMMY.
- From DMA_DUMMY, go to DMA_ALIGN if phase=1, else to DMA_READ.
- DMA_ALIGN SHALL go to DMA_READ.
REQ-025 DMA_READ: mem_addr={page,cnt}, mem_we=0; mem_rdata latched at the next edge.
- DMA_WRITE: mem_addr=16'h2004, mem_wdata=latched byte, mem_we=1, then cnt increments.
REQ-026 After the write with cnt=8'hFF, cnt SHALL wrap to 0 and the block SHALL return to arbitration.
- Total DMA duration SHALL be 513 cycles (even start) or 514 cycles (odd start).
REQ-027 dma_busy=1 in all DMA states; fetch_gnt=exec_gnt=0 throughout DMA.
REQ-028 dma_start while dma_busy=1 SHALL be ignored.
REQ-029 Simultaneous fetch_req and exec_req: exec SHALL win; fetch SHALL wait without loss.

Reset
REQ-030 Reset asserted SHALL immediately set the following, mid-DMA included:
- state=IDLE; DMA aborted.
- cnt=0, page=0, phase=0.
- mem_addr=0, mem_wdata=0, mem_we=0.
- fetch_gnt=0, exec_gnt=0, dma_busy=0.
REQ-031 On reset release, the first arbitration SHALL occur at the next rising phi1.

Configuration
REQ-032 Macro OAM_DMA_EN defined: DMA engine SHALL be compiled in per REQ-024..028.
REQ-033 OAM_DMA_EN undefined:
- dma_start and dma_page SHALL be ignored.
- dma_busy SHALL be constant 0.
- DMA states SHALL be absent; arbitration is exec > fetch only.

Structure
REQ-034 State encodings, DMA target address 16'h2004 and the REG_WIDTH/ADDR_WIDTH defaults SHALL reside in the shared defines header.
REQ-035 The DMA sequencer (page, cnt, phase, latched byte) SHALL be a sub-module named oam_dma_engine, instantiated only under OAM_DMA_EN.

Verification
REQ-036 fetch_req=1, fetch_addr=16'h8000 from IDLE:
- fetch_gnt=1 and mem_addr=16'h8000 after one edge.
- mem_rdata=8'hA9 sampled at the next edge.
REQ-037 fetch_req and exec_req (exec_we=1, exec_addr=16'h0010, exec_wdata=8'h55) asserted together:
- exec_gnt=1, mem_we=1, mem_wdata=8'h55 first.
- fetch_gnt=1 in the following cycle.
REQ-038 dma_start with dma_page=8'h02 at even phase:
- dma_busy=1 for exactly 513 cycles.
- Reads at 16'h0200..16'h02FF; 256 writes at 16'h2004 with matching data.
- Same stimulus at odd phase: 514 cycles.
REQ-039 exec_lock=1 held for 3 cycles, then dma_start:
- DMA_DUMMY begins only after exec_lock falls.
- A second dma_start mid-DMA has no effect.
REQ-040 reset_n pulsed low at DMA byte 100:
- All outputs reach reset values immediately.
- After release, fetch_req is granted normally; no further writes to 16'h2004.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared definitions for the memory bus arbiter.
// State encodings, bus width defaults and the OAM DMA target address.
// DMA states exist only when OAM_DMA_EN is defined.
package mem_arbiter_pkg;

    localparam int REG_WIDTH_DEF  = 8;
    localparam int ADDR_WIDTH_DEF = 16;
    localparam int STATE_W        = 3;

    // Every DMA write lands on the sprite data port.
    localparam logic [15:0] DMA_TARGET_ADDR = 16'h2004;

    typedef enum logic [STATE_W-1:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        EXEC      = 3'd2
`ifdef OAM_DMA_EN
        ,
        DMA_DUMMY = 3'd3,
        DMA_ALIGN = 3'd4,
        DMA_READ  = 3'd5,
        DMA_WRITE = 3'd6
`endif
    } state_t;

`ifdef OAM_DMA_EN
    // True for every state in which the DMA engine owns the bus.
    function automatic logic is_dma_state(input state_t s);
        return (s == DMA_DUMMY) || (s == DMA_ALIGN) ||
               (s == DMA_READ)  || (s == DMA_WRITE);
    endfunction
`endif

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester/memory signal bundle around the arbiter.
// slave modport is the arbiter view, master modport is the environment view.
//
// Handshake: a requester holds *_req (with its address/data) until it sees
// its *_gnt; a request sampled at rising edge k is answered by *_gnt and the
// bus signals after edge k, and the requester samples mem_rdata at edge k+1.
// A request not granted at an edge is simply re-evaluated at the next edge.
interface mem_arbiter_if import mem_arbiter_pkg::*; #(
    parameter int REG_WIDTH  = REG_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
);
    logic                  fetch_req;
    logic [ADDR_WIDTH-1:0] fetch_addr;
    logic                  exec_req;
    logic                  exec_we;
    logic [ADDR_WIDTH-1:0] exec_addr;
    logic [REG_WIDTH-1:0]  exec_wdata;
    logic                  exec_lock;
    logic                  dma_start;
    logic [REG_WIDTH-1:0]  dma_page;
    logic [REG_WIDTH-1:0]  mem_rdata;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [REG_WIDTH-1:0]  mem_wdata;
    logic                  mem_we;
    logic                  fetch_gnt;
    logic                  exec_gnt;
    logic                  dma_busy;
    logic [STATE_W-1:0]    dbg_state;

    modport slave (
        input  fetch_req, fetch_addr, exec_req, exec_we, exec_addr,
               exec_wdata, exec_lock, dma_start, dma_page, mem_rdata,
        output mem_addr, mem_wdata, mem_we, fetch_gnt, exec_gnt, dma_busy,
               dbg_state
    );

    modport master (
        output fetch_req, fetch_addr, exec_req, exec_we, exec_addr,
               exec_wdata, exec_lock, dma_start, dma_page, mem_rdata,
        input  mem_addr, mem_wdata, mem_we, fetch_gnt, exec_gnt, dma_busy,
               dbg_state
    );

endinterface

// File: rtl/mem_arbiter_oam_dma_engine.sv
// oam_dma_engine: OAM DMA sequencer datapath (page, byte counter, cycle
// phase, latched byte). Present only when OAM_DMA_EN is defined.
// It exposes the values it will hold after the current edge so the
// arbiter can register bus outputs in the same edge as the state change.
`ifdef OAM_DMA_EN
module oam_dma_engine import mem_arbiter_pkg::*; #(
    parameter int REG_WIDTH  = REG_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_load,
    input  logic [REG_WIDTH-1:0]  i_page,
    input  logic                  i_read,
    input  logic                  i_write,
    input  logic [REG_WIDTH-1:0]  i_rdata,
    output logic                  o_phase,
    output logic                  o_last,
    output logic [ADDR_WIDTH-1:0] o_next_rd_addr,
    output logic [REG_WIDTH-1:0]  o_next_byte
);

    logic                 r_phase;
    logic [REG_WIDTH-1:0] r_page;
    logic [REG_WIDTH-1:0] r_cnt;
    logic [REG_WIDTH-1:0] r_byte;
    logic [REG_WIDTH-1:0] w_page_next;
    logic [REG_WIDTH-1:0] w_cnt_next;
    logic [REG_WIDTH-1:0] w_byte_next;

    // Next-value logic: load on accepted start, count after each write,
    // capture read data at the edge that leaves the read cycle.
    always_comb begin
        w_page_next = i_load ? i_page : r_page;
        w_cnt_next  = r_cnt;
        if (i_load) begin
            w_cnt_next = '0;
        end else if (i_write) begin
            w_cnt_next = r_cnt + 1'b1;
        end
        w_byte_next = i_read ? i_rdata : r_byte;
    end

    // Sequencer registers; phase free-runs from reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_phase <= 1'b0;
            r_page  <= '0;
            r_cnt   <= '0;
            r_byte  <= '0;
        end else begin
            r_phase <= ~r_phase;
            r_page  <= w_page_next;
            r_cnt   <= w_cnt_next;
            r_byte  <= w_byte_next;
        end
    end

    assign o_phase        = r_phase;
    assign o_last         = (r_cnt == '1);
    assign o_next_rd_addr = ADDR_WIDTH'({w_page_next, w_cnt_next});
    assign o_next_byte    = w_byte_next;

endmodule
`endif

// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port memory bus arbiter, priority DMA > exec > fetch.
// All bus outputs and grants are registered from the next-state decision.
// Build option OAM_DMA_EN compiles in the OAM DMA engine; without it the
// block arbitrates exec > fetch only and dma_busy is tied low.
module mem_arbiter import mem_arbiter_pkg::*; #(
    parameter int REG_WIDTH  = REG_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic          phi1,
    input  logic          reset_n,
    mem_arbiter_if.slave  bus
);

    state_t                r_state;
    state_t                w_next_state;
    state_t                w_arb_state;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [ADDR_WIDTH-1:0] w_mem_addr;
    logic [REG_WIDTH-1:0]  r_mem_wdata;
    logic [REG_WIDTH-1:0]  w_mem_wdata;
    logic                  r_mem_we;
    logic                  w_mem_we;
    logic                  r_fetch_gnt;
    logic                  r_exec_gnt;
    logic                  w_exec_hold;

    // A locked exec access keeps the bus regardless of other requests.
    assign w_exec_hold = (r_state == EXEC) && bus.exec_lock;

`ifdef OAM_DMA_EN
    logic                  r_dma_pend;
    logic                  r_dma_busy;
    logic                  w_dma_busy;
    logic                  w_in_dma;
    logic                  w_dma_load;
    logic                  w_dma_req;
    logic                  w_phase;
    logic                  w_last_byte;
    logic [ADDR_WIDTH-1:0] w_dma_rd_addr;
    logic [REG_WIDTH-1:0]  w_dma_byte;

    // A start is accepted only when no DMA is running or already waiting.
    assign w_in_dma   = is_dma_state(r_state);
    assign w_dma_load = bus.dma_start && !w_in_dma && !r_dma_pend;
    assign w_dma_req  = r_dma_pend || w_dma_load;

    oam_dma_engine #(
        .REG_WIDTH  (REG_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_dma (
        .i_clk          (phi1),
        .i_rst_n        (reset_n),
        .i_load         (w_dma_load),
        .i_page         (bus.dma_page),
        .i_read         (r_state == DMA_READ),
        .i_write        (r_state == DMA_WRITE),
        .i_rdata        (bus.mem_rdata),
        .o_phase        (w_phase),
        .o_last         (w_last_byte),
        .o_next_rd_addr (w_dma_rd_addr),
        .o_next_byte    (w_dma_byte)
    );

    // Remember an accepted start that is blocked by an exec lock.
    always_ff @(posedge phi1 or negedge reset_n) begin
        if (!reset_n) begin
            r_dma_pend <= 1'b0;
        end else begin
            r_dma_pend <= w_dma_req && (w_next_state != DMA_DUMMY);
        end
    end
`else
    logic w_unused;
    assign w_unused = ^{bus.dma_start, bus.dma_page, bus.mem_rdata};
`endif

    // State register.
    always_ff @(posedge phi1 or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state: arbitration outside DMA, fixed sequence inside DMA.
    always_comb begin
        w_arb_state = IDLE;
        if (w_exec_hold) begin
            w_arb_state = EXEC;
`ifdef OAM_DMA_EN
        end else if (w_dma_req) begin
            w_arb_state = DMA_DUMMY;
`endif
        end else if (bus.exec_req) begin
            w_arb_state = EXEC;
        end else if (bus.fetch_req) begin
            w_arb_state = FETCH;
        end

        w_next_state = w_arb_state;
        case (r_state)
`ifdef OAM_DMA_EN
            DMA_DUMMY: w_next_state = w_phase ? DMA_ALIGN : DMA_READ;
            DMA_ALIGN: w_next_state = DMA_READ;
            DMA_READ:  w_next_state = DMA_WRITE;
            DMA_WRITE: w_next_state = w_last_byte ? w_arb_state : DMA_READ;
`endif
            default:   w_next_state = w_arb_state;
        endcase
    end

    // Output decode for the cycle about to start; address and data hold
    // their last value whenever the new owner does not drive them.
    always_comb begin
        w_mem_addr  = r_mem_addr;
        w_mem_wdata = r_mem_wdata;
        w_mem_we    = 1'b0;
`ifdef OAM_DMA_EN
        w_dma_busy  = 1'b0;
`endif
        case (w_next_state)
            FETCH: begin
                w_mem_addr = bus.fetch_addr;
            end
            EXEC: begin
                w_mem_addr  = bus.exec_addr;
                w_mem_wdata = bus.exec_wdata;
                w_mem_we    = bus.exec_we;
            end
`ifdef OAM_DMA_EN
            DMA_DUMMY, DMA_ALIGN: begin
                w_dma_busy = 1'b1;
            end
            DMA_READ: begin
                w_dma_busy = 1'b1;
                w_mem_addr = w_dma_rd_addr;
            end
            DMA_WRITE: begin
                w_dma_busy  = 1'b1;
                w_mem_addr  = ADDR_WIDTH'(DMA_TARGET_ADDR);
                w_mem_wdata = w_dma_byte;
                w_mem_we    = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    // Registered bus outputs and grants.
    always_ff @(posedge phi1 or negedge reset_n) begin
        if (!reset_n) begin
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_we    <= 1'b0;
            r_fetch_gnt <= 1'b0;
            r_exec_gnt  <= 1'b0;
`ifdef OAM_DMA_EN
            r_dma_busy  <= 1'b0;
`endif
        end else begin
            r_mem_addr  <= w_mem_addr;
            r_mem_wdata <= w_mem_wdata;
            r_mem_we    <= w_mem_we;
            r_fetch_gnt <= (w_next_state == FETCH);
            r_exec_gnt  <= (w_next_state == EXEC);
`ifdef OAM_DMA_EN
            r_dma_busy  <= w_dma_busy;
`endif
        end
    end

    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.mem_we    = r_mem_we;
    assign bus.fetch_gnt = r_fetch_gnt;
    assign bus.exec_gnt  = r_exec_gnt;
    assign bus.dbg_state = r_state;
`ifdef OAM_DMA_EN
    assign bus.dma_busy  = r_dma_busy;
`else
    assign bus.dma_busy  = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter.
// DMA scenarios run when OAM_DMA_EN is defined; otherwise the bench checks
// that DMA strobes are ignored.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int RW = 8;
    localparam int AW = 16;

    logic phi1 = 1'b0;
    logic reset_n;

    mem_arbiter_if #(.REG_WIDTH(RW), .ADDR_WIDTH(AW)) bus ();

    mem_arbiter #(.REG_WIDTH(RW), .ADDR_WIDTH(AW)) dut (
        .phi1    (phi1),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // ---------------- clock / reset ----------------
    always #5 phi1 = ~phi1;

    // Reference cycle phase: cleared by reset, toggles on every edge.
    logic tb_phase;
    always @(posedge phi1 or negedge reset_n) begin
        if (!reset_n) tb_phase <= 1'b0;
        else          tb_phase <= ~tb_phase;
    end

    // Memory model: fixed opcode at the reset vector area, pattern elsewhere.
    function automatic logic [RW-1:0] mem_model(input logic [AW-1:0] a);
        if (a == 16'h8000) return 8'hA9;
        return a[7:0] ^ a[15:8] ^ 8'h3C;
    endfunction

    assign bus.mem_rdata = mem_model(bus.mem_addr);

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [RW-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge phi1);
        #1;
    endtask

    task automatic clear_inputs();
        bus.fetch_req  = 1'b0;
        bus.fetch_addr = '0;
        bus.exec_req   = 1'b0;
        bus.exec_we    = 1'b0;
        bus.exec_addr  = '0;
        bus.exec_wdata = '0;
        bus.exec_lock  = 1'b0;
        bus.dma_start  = 1'b0;
        bus.dma_page   = '0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_addr"},  32'(bus.mem_addr),  32'h0);
        check({tag, "_wdata"}, 32'(bus.mem_wdata), 32'h0);
        check({tag, "_we"},    32'(bus.mem_we),    32'h0);
        check({tag, "_fgnt"},  32'(bus.fetch_gnt), 32'h0);
        check({tag, "_egnt"},  32'(bus.exec_gnt),  32'h0);
        check({tag, "_busy"},  32'(bus.dma_busy),  32'h0);
    endtask

`ifdef OAM_DMA_EN
    // Called in the first DMA cycle; follows the transfer to its end.
    task automatic run_dma(input logic [RW-1:0] page, input int exp_len, input bit poke);
        int n_cyc = 0;
        int n_wr  = 0;
        int n_gnt = 0;
        logic [AW-1:0] last_rd = '0;
        exp_q.delete();
        for (int i = 0; i < 256; i++) exp_q.push_back(mem_model({page, 8'(i)}));
        while (bus.dma_busy === 1'b1 && n_cyc < 600) begin
            n_cyc++;
            if (bus.fetch_gnt || bus.exec_gnt) n_gnt++;
            if (bus.mem_we) begin
                check("dma_rd_addr", 32'(last_rd), 32'({page, 8'(n_wr)}));
                check("dma_wr_addr", 32'(bus.mem_addr), 32'h2004);
                if (exp_q.size() > 0) check("dma_wr_data", 32'(bus.mem_wdata), 32'(exp_q.pop_front()));
                else                  check("dma_wr_count", 32'(n_wr + 1), 32'd256);
                n_wr++;
            end else begin
                last_rd = bus.mem_addr;
            end
            // A second start in the middle of the transfer must be ignored.
            bus.dma_start = poke && (n_cyc == 50);
            if (poke && n_cyc == 50) bus.dma_page = 8'h07;
            tick();
        end
        bus.dma_start = 1'b0;
        check("dma_len",     32'(n_cyc), 32'(exp_len));
        check("dma_writes",  32'(n_wr),  32'd256);
        check("dma_cpu_gnt", 32'(n_gnt), 32'd0);
    endtask

    // Strobe so that the DMA_DUMMY cycle lands on the requested phase;
    // the dummy cycle carries the inverse of the strobe cycle's phase.
    task automatic start_dma(input logic [RW-1:0] page, input bit odd);
        int guard = 0;
        while (tb_phase !== ~odd && guard < 4) begin
            tick();
            guard++;
        end
        bus.dma_start = 1'b1;
        bus.dma_page  = page;
        tick();
        bus.dma_start = 1'b0;
        check("dma_busy_start", 32'(bus.dma_busy), 32'h1);
        check("dma_dummy_phase", 32'(tb_phase), 32'(odd));
    endtask
`endif

    // ---------------- stimulus ----------------
    initial begin
        reset_n = 1'b1;
        clear_inputs();
        #2 reset_n = 1'b0;
        #1 check_reset_outputs("reset");
        repeat (2) @(posedge phi1);
        #1 check_reset_outputs("reset_held");
        reset_n = 1'b1;

        // Fetch from IDLE: granted after one edge, data valid in that cycle.
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = 16'h8000;
        tick();
        check("fetch_gnt",   32'(bus.fetch_gnt), 32'h1);
        check("fetch_addr",  32'(bus.mem_addr),  32'h8000);
        check("fetch_we",    32'(bus.mem_we),    32'h0);
        check("fetch_rdata", 32'(bus.mem_rdata), 32'hA9);

        // No request: IDLE, address held.
        bus.fetch_req = 1'b0;
        tick();
        check("idle_fgnt", 32'(bus.fetch_gnt), 32'h0);
        check("idle_egnt", 32'(bus.exec_gnt),  32'h0);
        check("idle_we",   32'(bus.mem_we),    32'h0);
        check("idle_addr", 32'(bus.mem_addr),  32'h8000);

        // Simultaneous requests: exec write first, fetch next.
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = 16'h8123;
        bus.exec_req   = 1'b1;
        bus.exec_we    = 1'b1;
        bus.exec_addr  = 16'h0010;
        bus.exec_wdata = 8'h55;
        tick();
        check("both_egnt",  32'(bus.exec_gnt),  32'h1);
        check("both_fgnt",  32'(bus.fetch_gnt), 32'h0);
        check("both_we",    32'(bus.mem_we),    32'h1);
        check("both_wdata", 32'(bus.mem_wdata), 32'h55);
        check("both_addr",  32'(bus.mem_addr),  32'h0010);
        bus.exec_req = 1'b0;
        bus.exec_we  = 1'b0;
        tick();
        check("wait_fgnt", 32'(bus.fetch_gnt), 32'h1);
        check("wait_egnt", 32'(bus.exec_gnt),  32'h0);
        check("wait_addr", 32'(bus.mem_addr),  32'h8123);
        check("wait_we",   32'(bus.mem_we),    32'h0);
        bus.fetch_req = 1'b0;

        // Locked exec read keeps the bus after its request drops.
        bus.exec_req  = 1'b1;
        bus.exec_lock = 1'b1;
        bus.exec_addr = 16'h1234;
        tick();
        check("lock_egnt0", 32'(bus.exec_gnt), 32'h1);
        check("lock_addr0", 32'(bus.mem_addr), 32'h1234);
        bus.exec_req   = 1'b0;
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = 16'h4000;
        tick();
        check("lock_egnt1", 32'(bus.exec_gnt),  32'h1);
        check("lock_fgnt1", 32'(bus.fetch_gnt), 32'h0);
        bus.exec_lock = 1'b0;
        tick();
        check("unlock_fgnt", 32'(bus.fetch_gnt), 32'h1);
        check("unlock_addr", 32'(bus.mem_addr),  32'h4000);
        clear_inputs();
        tick();

`ifdef OAM_DMA_EN
        // Even-phase and odd-phase transfers from page 2.
        start_dma(8'h02, 1'b0);
        run_dma(8'h02, 513, 1'b0);
        check("dma_even_end_addr", 32'(bus.mem_addr), 32'h2004);
        tick();
        start_dma(8'h02, 1'b1);
        run_dma(8'h02, 514, 1'b0);

        // DMA waits behind a 3-cycle exec lock; mid-DMA restart ignored.
        bus.exec_req   = 1'b1;
        bus.exec_lock  = 1'b1;
        bus.exec_addr  = 16'h0300;
        tick();
        check("dlock_egnt0", 32'(bus.exec_gnt), 32'h1);
        bus.dma_start = 1'b1;
        bus.dma_page  = 8'h03;
        tick();
        bus.dma_start = 1'b0;
        check("dlock_egnt1", 32'(bus.exec_gnt), 32'h1);
        check("dlock_busy1", 32'(bus.dma_busy), 32'h0);
        tick();
        check("dlock_egnt2", 32'(bus.exec_gnt), 32'h1);
        check("dlock_busy2", 32'(bus.dma_busy), 32'h0);
        bus.exec_lock = 1'b0;
        bus.exec_req  = 1'b0;
        tick();
        check("dlock_go_busy", 32'(bus.dma_busy), 32'h1);
        check("dlock_go_egnt", 32'(bus.exec_gnt), 32'h0);
        run_dma(8'h03, tb_phase ? 514 : 513, 1'b1);
        tick();
        check("dma_no_restart", 32'(bus.dma_busy), 32'h0);

        // Reset in the middle of a transfer, at byte 100.
        begin
            int n_wr = 0;
            int guard = 0;
            start_dma(8'h02, 1'b0);
            while (n_wr < 100 && guard < 400) begin
                if (bus.mem_we) n_wr++;
                tick();
                guard++;
            end
            check("rst_byte_reached", 32'(n_wr), 32'd100);
        end
        #2 reset_n = 1'b0;
        #1 check_reset_outputs("rst_mid_dma");
        tick();
        check_reset_outputs("rst_mid_dma_held");
        reset_n = 1'b1;
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = 16'h9000;
        tick();
        check("rst_fetch_gnt",  32'(bus.fetch_gnt), 32'h1);
        check("rst_fetch_addr", 32'(bus.mem_addr),  32'h9000);
        check("rst_fetch_busy", 32'(bus.dma_busy),  32'h0);
        begin
            int n_oam = 0;
            for (int i = 0; i < 40; i++) begin
                if (bus.mem_we && bus.mem_addr == 16'h2004) n_oam++;
                tick();
            end
            check("rst_no_oam_writes", 32'(n_oam), 32'd0);
        end
`else
        // DMA strobe has no effect when the engine is not built.
        bus.dma_start  = 1'b1;
        bus.dma_page   = 8'h02;
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = 16'h4567;
        tick();
        bus.dma_start = 1'b0;
        check("nodma_busy0", 32'(bus.dma_busy),  32'h0);
        check("nodma_fgnt",  32'(bus.fetch_gnt), 32'h1);
        check("nodma_addr",  32'(bus.mem_addr),  32'h4567);
        tick();
        check("nodma_busy1", 32'(bus.dma_busy),  32'h0);
        check("nodma_we",    32'(bus.mem_we),    32'h0);
`endif
        clear_inputs();
        tick();

        // ---------------- report ----------------
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Watchdog: the whole run is far shorter than this.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
